// File: rtl/series_eval_pkg.sv
// Shared types and fixed-point helpers for the series evaluator.
// Truncating Q-format multiply: keeps product bits [W+FRAC-1:FRAC].
package series_eval_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SQUARE = 3'd1,
      ST_MUL_X  = 3'd2,
      ST_MUL_C  = 3'd3,
      ST_ACC    = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam int unsigned MUL_W = 32;

   function automatic logic [MUL_W-1:0] fx_one(input int frac);
      return MUL_W'(1) << frac;
   endfunction

   // Caller truncates the returned value to W bits, discarding the upper product bits.
   function automatic logic [MUL_W-1:0] fx_mul(input logic [MUL_W-1:0] a,
                                               input logic [MUL_W-1:0] b,
                                               input int frac);
      logic [2*MUL_W-1:0] prod;
      logic [2*MUL_W-1:0] shifted;
      prod    = {{MUL_W{1'b0}}, a} * {{MUL_W{1'b0}}, b};
      shifted = prod >> frac;
      return shifted[MUL_W-1:0];
   endfunction

endpackage

// File: rtl/series_eval_engine_coef.sv
// Coefficient table for series_eval_engine: writes gated off while busy,
// asynchronous read, every entry resets to ONE.
module series_coef_ram
   import series_eval_pkg::*;
#(
   parameter int W     = 10,
   parameter int FRAC  = 8,
   parameter int NCOEF = 4,
   parameter int AW    = $clog2(NCOEF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          busy,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   localparam logic [W-1:0] ONE = W'(fx_one(FRAC));

   logic [W-1:0] mem_r [NCOEF];

   // Table storage: reset to unity, write only when no run is in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCOEF; i++) begin
            mem_r[i] <= ONE;
         end
      end else if (wr_en && !busy) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/series_eval_engine.sv
// Self-sequencing power-series evaluator: result = 1 - c0*x^2 + c0*c1*x^4 - ...
// Optional build macro SERIES_SATURATE_EN: clamp the accumulator and report overflow.
module series_eval_engine
   import series_eval_pkg::*;
#(
   parameter int W         = 10,
   parameter int FRAC      = 8,
   parameter int NCOEF     = 4,
   parameter int MAX_TERMS = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [W-1:0]                   x,
   input  logic [W-1:0]                   threshold,
   input  logic                           coef_wr_en,
   input  logic [$clog2(NCOEF)-1:0]       coef_wr_addr,
   input  logic [W-1:0]                   coef_wr_data,
   output logic                           busy,
   output logic                           done,
   output logic [W-1:0]                   result,
   output logic [$clog2(MAX_TERMS+1)-1:0] term_count,
   output logic                           overflow
);

   localparam int AW = $clog2(NCOEF);
   localparam int CW = $clog2(MAX_TERMS+1);
   localparam logic [W-1:0] ONE = W'(fx_one(FRAC));

   state_t         state_r;
   logic [W-1:0]   x_r;
   logic [W-1:0]   thr_r;
   logic [W-1:0]   x2_r;
   logic [W-1:0]   term_r;
   logic [W-1:0]   result_r;
   logic [AW-1:0]  k_r;
   logic           sign_sub_r;
   logic [CW-1:0]  term_count_r;
   logic           busy_r;
   logic           done_r;
   logic           overflow_r;

   logic [W-1:0]   coef_s;
   logic [W-1:0]   mul_a_s;
   logic [W-1:0]   mul_b_s;
   logic [W-1:0]   mul_s;
   logic [W-1:0]   acc_val_s;
   logic           acc_clamp_s;
   logic           stop_s;

   series_coef_ram #(
      .W     (W),
      .FRAC  (FRAC),
      .NCOEF (NCOEF),
      .AW    (AW)
   ) u_coef (
      .clk     (clk),
      .rst     (rst),
      .busy    (busy_r),
      .wr_en   (coef_wr_en),
      .wr_addr (coef_wr_addr),
      .wr_data (coef_wr_data),
      .rd_addr (k_r),
      .rd_data (coef_s)
   );

   // One shared multiplier; operands chosen by the current state.
   always_comb begin
      mul_a_s = x_r;
      mul_b_s = x_r;
      case (state_r)
         ST_MUL_X: begin
            mul_a_s = term_r;
            mul_b_s = x2_r;
         end
         ST_MUL_C: begin
            mul_a_s = term_r;
            mul_b_s = coef_s;
         end
         default: begin
            mul_a_s = x_r;
            mul_b_s = x_r;
         end
      endcase
   end

   assign mul_s  = W'(fx_mul(MUL_W'(mul_a_s), MUL_W'(mul_b_s), FRAC));
   assign stop_s = (term_r < thr_r) || (term_count_r == CW'(MAX_TERMS));

`ifdef SERIES_SATURATE_EN
   logic [W:0] acc_sum_s;

   // Accumulate in W+1 bits; bit W flags carry (add) or borrow (subtract).
   always_comb begin
      acc_sum_s = '0;
      if (sign_sub_r) begin
         acc_sum_s = {1'b0, result_r} - {1'b0, term_r};
      end else begin
         acc_sum_s = {1'b0, result_r} + {1'b0, term_r};
      end
      if (acc_sum_s[W]) begin
         acc_val_s   = sign_sub_r ? {W{1'b0}} : {W{1'b1}};
         acc_clamp_s = 1'b1;
      end else begin
         acc_val_s   = acc_sum_s[W-1:0];
         acc_clamp_s = 1'b0;
      end
   end
`else
   // Modulo-2^W accumulation; clamping never happens in this build.
   always_comb begin
      acc_val_s   = '0;
      acc_clamp_s = 1'b0;
      if (sign_sub_r) begin
         acc_val_s = result_r - term_r;
      end else begin
         acc_val_s = result_r + term_r;
      end
   end
`endif

   // Controller FSM with the datapath registers it sequences.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         x_r          <= '0;
         thr_r        <= '0;
         x2_r         <= '0;
         term_r       <= '0;
         result_r     <= '0;
         k_r          <= '0;
         sign_sub_r   <= 1'b0;
         term_count_r <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         overflow_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  x_r          <= x;
                  thr_r        <= threshold;
                  term_r       <= ONE;
                  result_r     <= ONE;
                  k_r          <= '0;
                  sign_sub_r   <= 1'b1;
                  term_count_r <= '0;
                  overflow_r   <= 1'b0;
                  busy_r       <= 1'b1;
                  state_r      <= ST_SQUARE;
               end
            end
            ST_SQUARE: begin
               x2_r    <= mul_s;
               state_r <= ST_MUL_X;
            end
            ST_MUL_X: begin
               term_r  <= mul_s;
               state_r <= ST_MUL_C;
            end
            ST_MUL_C: begin
               term_r  <= mul_s;
               state_r <= ST_ACC;
            end
            ST_ACC: begin
               if (stop_s) begin
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  result_r     <= acc_val_s;
                  overflow_r   <= overflow_r | acc_clamp_s;
                  term_count_r <= term_count_r + CW'(1);
                  k_r          <= k_r + AW'(1);
                  sign_sub_r   <= ~sign_sub_r;
                  state_r      <= ST_MUL_X;
               end
            end
            ST_DONE: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign result     = result_r;
   assign term_count = term_count_r;
   assign overflow   = overflow_r;

endmodule

// File: doc/series_eval_engine.md
# series_eval_engine

Parametrised fixed-point power-series evaluator with its own controller and a writable coefficient table. It computes result = 1 − c0·x² + c1·x⁴·… (alternating signs, running product of coefficients), stopping when the next term falls below a threshold or a term cap is reached. It sits behind the arithmetic front end as a self-sequencing unit with a start/done handshake.

## Interface
- W, 10: data width (unsigned, FRAC fraction bits)
- FRAC, 8: fraction bits; ONE = 1<<FRAC
- NCOEF, 4: coefficient table depth (power of 2, ≥2)
- MAX_TERMS, 16: maximum accumulated terms per run
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run (sampled only in IDLE)
- x  in  W  argument, captured on accepted start
- threshold  in  W  stop threshold, captured on accepted start
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  $clog2(NCOEF)  write index
- coef_wr_data  in  W  coefficient value
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- result  out  W  final sum, held until next accepted start
- term_count  out  $clog2(MAX_TERMS+1)  terms accumulated
- overflow  out  1  sticky per run; set when accumulator clamped

## Operation
- Reset: state IDLE; busy, done, result, term_count, overflow = 0; all coefficients = ONE.
- Multiply rule: unsigned W×W full product, keep bits [W+FRAC−1:FRAC] (truncate, upper bits discarded).
- States: IDLE, SQUARE, MUL_X, MUL_C, ACC, DONE.
- IDLE + start: capture x, threshold; term←ONE, result←ONE, k←0, sign←subtract, term_count←0, overflow←0; → SQUARE. start in any other state ignored.
- SQUARE: x2←x·x; → MUL_X.
- MUL_X: term←term·x2; → MUL_C.
- MUL_C: term←term·coef[k]; → ACC.
- ACC: if term < threshold (unsigned) or term_count == MAX_TERMS → DONE, result unchanged. Else result←result ∓ term per sign, term_count++, k←(k+1) mod NCOEF, sign toggles; → MUL_X.
- DONE: done=1 for this cycle; → IDLE.
- Coefficient writes: accepted only when busy=0; ignored while busy.
- Reset mid-run: immediate return to IDLE with reset values; coefficient table also reset.

## Timing
- Start accepted at edge 0; run accumulating n terms asserts done in the cycle after edge 3n+4 (n=0 → 4 cycles).
- busy rises the cycle after edge 0, falls the cycle after done.
- result, term_count, overflow valid while done=1 and stable until next accepted start.
- start asserted during the DONE cycle is ignored; a new start is accepted the next cycle.
- Coefficient write takes effect at the clock edge; readable by a run started the following cycle.

## Configuration
- SERIES_SATURATE_EN defined: ACC add/subtract saturates to [0, 2^W−1]; any clamp sets overflow.
- Undefined: ACC wraps modulo 2^W; overflow tied to 0.

## Structure
- Package series_eval_pkg: state enum, ONE constant, fixed-point multiply function (truncation rule).
- Sub-module series_coef_ram: NCOEF×W register table, write port with busy gating, asynchronous read by k, reset to ONE.
- FSM, term/result/x2 registers and accumulator in the top module.

## Test plan (W=10, FRAC=8, NCOEF=4, MAX_TERMS=16)
- x=0, threshold=0x001 → done after 4 cycles, result=0x100, term_count=0, overflow=0.
- Coefs all 0x080, x=0x100, threshold=0x010 → terms 0x080,0x040,0x020,0x010 added; result=0x0B0, term_count=4, done after 16 cycles.
- Coefs all 0x100, x=0x100, threshold=0 → term cap hit; result=0x100, term_count=16, done after 52 cycles.
- coef[0]=0x100, coef[1]=0, x=0x16A, threshold=0x1FF → term_count=1; with SERIES_SATURATE_EN result=0x000, overflow=1; without result=0x301, overflow=0.
- start pulsed again and coef write (addr 0, 0x000) issued mid-run → both ignored; result matches scenario 2; write after done applies.
- rst asserted mid-run (in MUL_C) → next cycle busy=0, result=0, coefficients=0x100; fresh start runs normally.
